// File: rtl/irda_wb_cmd_seq_pkg.sv
// Shared types for the IrDA Wishbone command sequencer.
// State encodings match the IRDA_SEQ_* constants used elsewhere in the IrDA codebase.
package irda_wb_cmd_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/irda_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers; the extra pointer MSB
// distinguishes full from empty.
module irda_cmd_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (PW+1)'(1);
      if (do_pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= din;
  end

  assign dout  = mem[rptr[PW-1:0]];
  assign level = LW'(wptr - rptr);
  assign full  = (level == LW'(DEPTH));
  assign empty = (wptr == rptr);

endmodule

// File: rtl/irda_wb_cmd_seq.sv
// Wishbone master command sequencer: executes buffered read/write commands as
// single classic cycles with an ack timeout and returns one response per command.
module irda_wb_cmd_seq
  import irda_wb_cmd_seq_pkg::*;
#(
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       wb_rst_i,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [AW-1:0]              cmd_addr,
  input  logic [DW-1:0]              cmd_dat,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DW-1:0]              rsp_dat,
  output logic                       rsp_err,
  output logic [AW-1:0]              wb_addr_o,
  output logic [DW-1:0]              wb_dat_o,
  input  logic [DW-1:0]              wb_dat_i,
  output logic                       wb_we_o,
  output logic                       wb_stb_o,
  output logic                       wb_cyc_o,
  input  logic                       wb_ack_i,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int FW = 1 + AW + DW;
  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_e    state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_next;
  logic [FW-1:0] head;
  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  // Pop only from IDLE, on the same edge that launches the Wishbone cycle.
  assign pop = (state == SEQ_IDLE) && !fifo_empty;

  irda_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (wb_rst_i),
    .push  (cmd_valid),
    .din   ({cmd_we, cmd_addr, cmd_dat}),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_we, head_addr, head_dat} = head;
  assign tmo_next  = tmo_cnt + CW'(1);
  assign cmd_ready = !fifo_full;
  assign busy      = (state != SEQ_IDLE) || !fifo_empty;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state     <= SEQ_IDLE;
      tmo_cnt   <= '0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (!fifo_empty) begin
            wb_addr_o <= head_addr;
            wb_dat_o  <= head_dat;
            wb_we_o   <= head_we;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: begin
          // An ack on the final timeout cycle still completes the cycle normally.
          if (wb_ack_i) begin
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= SEQ_RESP;
          end else if (tmo_next == CW'(TIMEOUT)) begin
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= SEQ_RESP;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        SEQ_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= SEQ_IDLE;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irda_wb_cmd_seq.sv
// Directed bench for irda_wb_cmd_seq (DEPTH=4, TIMEOUT=8) with a behavioural
// Wishbone slave that acks one cycle after stb when enabled.
module tb_irda_wb_cmd_seq;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_we_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic          wb_ack_i = 1'b0;
  logic          busy;
  logic [LW-1:0] fifo_level;

  logic          ack_en;
  logic [DW-1:0] rd_data;
  int            tests_run = 0;
  int            errors = 0;
  int            rsp_cnt = 0;
  int            rsp_err_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_dat[$];

  irda_wb_cmd_seq #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_dat    (cmd_dat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .wb_addr_o  (wb_addr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  assign wb_dat_i = rd_data;

  // Slave: ack appears at the negedge after stb rises, so it is sampled one cycle later.
  always @(negedge clk) wb_ack_i = wb_stb_o && ack_en;

  always @(posedge clk) begin
    if (!wb_rst_i && wb_stb_o && wb_ack_i) begin
      log_addr.push_back(wb_addr_o);
      log_dat.push_back(wb_dat_o);
    end
    if (!wb_rst_i && rsp_valid && rsp_ready) begin
      rsp_cnt     <= rsp_cnt + 1;
      rsp_err_cnt <= rsp_err_cnt + int'(rsp_err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one command once cmd_ready is seen; returns at the negedge after the push edge.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready_wait", 64'(n < 200), 64'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_dat   = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // One command from an idle, empty engine against the k=1 slave.
  task automatic do_cmd(input string tag, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    push(we, a, d);
    check({tag, "_nobypass_cyc"}, 64'(wb_cyc_o), 64'd0);
    check({tag, "_level1"}, 64'(fifo_level), 64'd1);
    @(negedge clk);
    check({tag, "_cyc"}, 64'(wb_cyc_o), 64'd1);
    check({tag, "_stb"}, 64'(wb_stb_o), 64'd1);
    check({tag, "_we"}, 64'(wb_we_o), 64'(we));
    check({tag, "_addr"}, 64'(wb_addr_o), 64'(a));
    check({tag, "_wdat"}, 64'(wb_dat_o), 64'(d));
    check({tag, "_level0"}, 64'(fifo_level), 64'd0);
    @(negedge clk);
    check({tag, "_cyc_drop"}, 64'(wb_cyc_o), 64'd0);
    check({tag, "_stb_drop"}, 64'(wb_stb_o), 64'd0);
    check({tag, "_we_drop"}, 64'(wb_we_o), 64'd0);
    check({tag, "_addr_hold"}, 64'(wb_addr_o), 64'(a));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_dat"}, 64'(rsp_dat), 64'(exp_rd));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_released"}, 64'(rsp_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    int lb;
    int rb;
    int eb;
    logic any_rsp;

    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    ack_en    = 1'b1;
    rd_data   = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    wb_rst_i = 1'b0;

    // Reset values
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_wb_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_wb_stb", 64'(wb_stb_o), 64'd0);
    check("rst_wb_we", 64'(wb_we_o), 64'd0);
    check("rst_wb_addr", 64'(wb_addr_o), 64'd0);
    check("rst_wb_dat", 64'(wb_dat_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);

    // Write sequence: responses carry zero data even though the slave drives data
    do_cmd("wr0", 1'b1, 4'h0, 32'h0000_001B, 32'h0);
    do_cmd("wr1", 1'b1, 4'h4, 32'd200000, 32'h0);

    // Read
    rd_data = 32'h44332211;
    do_cmd("rd8", 1'b0, 4'h8, 32'h0, 32'h44332211);

    // Timeout: stb high for exactly TIMEOUT cycles, error response, zero data
    ack_en = 1'b0;
    push(1'b0, 4'hC, 32'h0);
    @(negedge clk);
    n = 0;
    while (wb_stb_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo_stb_cycles", 64'(n), 64'(TIMEOUT));
    check("tmo_cyc_low", 64'(wb_cyc_o), 64'd0);
    check("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    check("tmo_rsp_err", 64'(rsp_err), 64'd1);
    check("tmo_rsp_dat", 64'(rsp_dat), 64'd0);
    ack_en = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("tmo_released", 64'(rsp_valid), 64'd0);
    rd_data = 32'hCAFE0001;
    do_cmd("after_tmo", 1'b0, 4'h3, 32'h0, 32'hCAFE0001);

    // Full FIFO and backpressure; second push coincides with the first pop
    lb = log_addr.size();
    rb = rsp_cnt;
    eb = rsp_err_cnt;
    push(1'b1, 4'd0, 32'h100);
    push(1'b1, 4'd1, 32'h101);
    check("pushpop_level1", 64'(fifo_level), 64'd1);
    push(1'b1, 4'd2, 32'h102);
    push(1'b1, 4'd3, 32'h103);
    push(1'b1, 4'd4, 32'h104);
    check("full_cmd_ready", 64'(cmd_ready), 64'd0);
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_parked_rsp", 64'(rsp_valid), 64'd1);
    check("full_parked_stb", 64'(wb_stb_o), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("full_hold_level", 64'(fifo_level), 64'd4);
    fork
      push(1'b1, 4'd5, 32'h105);
      begin
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_cnt < rb + 6 && n < 200) begin
          @(negedge clk);
          n++;
        end
        rsp_ready = 1'b0;
      end
    join
    check("drain_rsp_count", 64'(rsp_cnt - rb), 64'd6);
    check("drain_rsp_errs", 64'(rsp_err_cnt - eb), 64'd0);
    check("drain_wb_count", 64'(log_addr.size() - lb), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("drain_addr%0d", i), 64'(log_addr[lb+i]), 64'(i));
      check($sformatf("drain_dat%0d", i), 64'(log_dat[lb+i]), 64'(32'h100 + i));
    end
    check("drain_idle", 64'(busy), 64'd0);

    // Reset while stb is high with two commands queued
    ack_en = 1'b0;
    push(1'b1, 4'hA, 32'h1);
    push(1'b1, 4'hB, 32'h2);
    push(1'b1, 4'hC, 32'h3);
    check("rstmid_stb_before", 64'(wb_stb_o), 64'd1);
    check("rstmid_level_before", 64'(fifo_level), 64'd2);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    ack_en = 1'b1;
    check("rstmid_cyc", 64'(wb_cyc_o), 64'd0);
    check("rstmid_stb", 64'(wb_stb_o), 64'd0);
    check("rstmid_level", 64'(fifo_level), 64'd0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_cmd_ready", 64'(cmd_ready), 64'd1);
    any_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      any_rsp = any_rsp | rsp_valid | wb_stb_o;
    end
    check("rstmid_no_activity", 64'(any_rsp), 64'd0);
    rd_data = 32'h0BADF00D;
    do_cmd("after_rst", 1'b0, 4'h5, 32'h0, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule

// File: doc/irda_wb_cmd_seq.md
# irda_wb_cmd_seq

Parametrised Wishbone master command sequencer. It replaces hand-driven register programming of `irda_top` cores with a buffered hardware engine. A host pushes read/write commands into a FIFO; the engine executes each one as a single Wishbone classic cycle with an ack timeout and returns one response per command. Instances sit between a controller (CPU shim, boot ROM, DMA) and one or more `irda_top` register ports.

## Interface

Parameters:
- `AW`, 4: Wishbone address width.
- `DW`, 32: data width.
- `DEPTH`, 8: command FIFO depth; power of two, ≥2.
- `TIMEOUT`, 255: maximum number of cycles with `wb_stb_o` high and no ack before the cycle is aborted; 1..65535.

Ports:
- `clk`  in  1  single clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AW  target address.
- `cmd_dat`  in  DW  write data; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_dat`  out  DW  read data; 0 for writes and for errors.
- `rsp_err`  out  1  ack timeout occurred.
- `wb_addr_o`  out  AW  Wishbone address.
- `wb_dat_o`  out  DW  Wishbone write data.
- `wb_dat_i`  in  DW  Wishbone read data.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_ack_i`  in  1  Wishbone ack.
- `busy`  out  1  high when the state is not IDLE or the FIFO is non-empty.
- `fifo_level`  out  $clog2(DEPTH+1)  number of buffered commands.

## Operation

- Push: a command is written on an edge where `cmd_valid && cmd_ready`. There is no bypass. When the FIFO is full, `cmd_ready`=0 even if a pop happens in the same cycle.
- State machine, in three states:
  - **IDLE**: if the FIFO is non-empty, pop the head command. On the same edge, register `wb_addr_o`, `wb_dat_o` and `wb_we_o`, set `wb_cyc_o`=`wb_stb_o`=1, clear the timeout counter, and go to ISSUE.
  - **ISSUE**:
    - If `wb_ack_i` is sampled high: drop cyc/stb. For a read, capture `wb_dat_i` into `rsp_dat`; for a write, set `rsp_dat`=0. Set `rsp_err`=0 and `rsp_valid`=1, then go to RESP.
    - Otherwise increment the counter. When the counter reaches `TIMEOUT`: drop cyc/stb, set `rsp_err`=1, `rsp_dat`=0, `rsp_valid`=1, and go to RESP.
  - **RESP**: hold `rsp_*` stable until an edge with `rsp_ready`=1. On that edge clear `rsp_valid` and go to IDLE. While in RESP, no new Wishbone cycle starts; backpressure fills the FIFO.
- Commands execute strictly in order, with exactly one response per command.
- `wb_we_o` is cleared when cyc drops. `wb_addr_o` and `wb_dat_o` hold their last value.
- A late ack arriving after a timeout abort is ignored, because stb is already low.

## Timing

- Reset values: `cmd_ready`=1; `rsp_valid`=0, `rsp_dat`=0, `rsp_err`=0; all `wb_*_o`=0; `busy`=0; `fifo_level`=0; state IDLE.
- Reset mid-operation flushes the FIFO and aborts any open cycle. cyc/stb are low after the reset edge, and no response is produced for flushed or aborted commands.
- Latency for an empty FIFO:
  - command accepted at edge N;
  - `wb_cyc_o`/`wb_stb_o` high after edge N+1;
  - with ack sampled at edge N+1+k (k ≥ 1), `rsp_valid` is high and cyc/stb are low after that edge.
- Timeout: stb stays high for exactly `TIMEOUT` cycles.
- Back-to-back with `rsp_ready` tied high: response released at edge M, next cyc/stb high after edge M+1. Minimum spacing between cycle starts is 3 cycles for k=1.
- `fifo_level` reflects pushes and pops of the previous edge. A simultaneous push and pop leaves it unchanged.

## Structure

- State encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) are added to the shared `irda_defines.v` as `IRDA_SEQ_*` constants.
- One sub-module, `irda_cmd_fifo`:
  - synchronous FIFO of width 1+AW+DW and depth `DEPTH`;
  - wrap-around read/write pointers with an extra MSB for the full/empty distinction;
  - outputs `level`, `full` and `empty`.
- The top level holds the FSM, the Wishbone output registers, the timeout counter ($clog2(TIMEOUT+1) bits) and the response registers.

## Test plan

1. **Write sequence.** Push write 0x0←0x1B, then write 0x4←200000, against a slave that acks one cycle after stb. Expect: two Wishbone cycles in order with matching address and data; two responses, each with `rsp_err`=0 and `rsp_dat`=0.
2. **Read.** Push read 0x8 against a slave returning 0x44332211. Expect: `wb_we_o`=0 during the cycle; response `rsp_dat`=0x44332211, `rsp_err`=0.
3. **Timeout.** Set `TIMEOUT`=8 and never ack. Expect: stb high for exactly 8 cycles, then `rsp_err`=1, `rsp_dat`=0. A following command with ack completes normally.
4. **Full FIFO and backpressure.** Set `DEPTH`=4 and hold `rsp_ready`=0. Push 6 commands. Expect: the first executes and parks in RESP; 4 are buffered; `cmd_ready`=0 with `fifo_level`=4. Releasing `rsp_ready` drains all commands in order.
5. **Reset during ISSUE.** Assert `wb_rst_i` while stb is high with 2 commands queued. Expect: cyc/stb low and `fifo_level`=0 next cycle, and no `rsp_valid`.
6. **Simultaneous push/pop at level 1.** Expect: `fifo_level` stays at 1 and both commands execute.
